// File: rtl/hpdcache_mem_responder.sv
// Memory-side responder for the HPDcache memory interface: independent single-outstanding
// read and write FSMs in front of a register-array backing store.
module hpdcache_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 56,
  parameter int unsigned ID_WIDTH   = 7,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned MEM_WORDS  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    mem_req_read_valid_i,
  output logic                    mem_req_read_ready_o,
  input  logic [ADDR_WIDTH-1:0]   mem_req_read_addr_i,
  input  logic [7:0]              mem_req_read_len_i,
  input  logic [ID_WIDTH-1:0]     mem_req_read_id_i,
  input  logic [1:0]              mem_req_read_cmd_i,

  output logic                    mem_resp_read_valid_o,
  input  logic                    mem_resp_read_ready_i,
  output logic [DATA_WIDTH-1:0]   mem_resp_read_data_o,
  output logic [ID_WIDTH-1:0]     mem_resp_read_id_o,
  output logic                    mem_resp_read_last_o,
  output logic                    mem_resp_read_error_o,

  input  logic                    mem_req_write_valid_i,
  output logic                    mem_req_write_ready_o,
  input  logic [ADDR_WIDTH-1:0]   mem_req_write_addr_i,
  input  logic [7:0]              mem_req_write_len_i,
  input  logic [ID_WIDTH-1:0]     mem_req_write_id_i,
  input  logic [1:0]              mem_req_write_cmd_i,

  input  logic                    mem_req_write_data_valid_i,
  output logic                    mem_req_write_data_ready_o,
  input  logic [DATA_WIDTH-1:0]   mem_req_write_data_i,
  input  logic [DATA_WIDTH/8-1:0] mem_req_write_data_be_i,
  input  logic                    mem_req_write_data_last_i,

  output logic                    mem_resp_write_valid_o,
  input  logic                    mem_resp_write_ready_i,
  output logic [ID_WIDTH-1:0]     mem_resp_write_id_o,
  output logic                    mem_resp_write_error_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_W    = $clog2(BE_WIDTH);
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
  localparam int unsigned HI_LSB   = OFF_W + IDX_W;

  localparam logic [1:0]       CMD_READ  = 2'b00;
  localparam logic [1:0]       CMD_WRITE = 2'b01;
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_BURST = 1'b1} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE = 2'b00, WR_DATA = 2'b01, WR_RESP = 2'b10} wr_state_e;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] addr);
    return |addr[ADDR_WIDTH-1:HI_LSB];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] upd,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    for (int b = 0; b < BE_WIDTH; b++) begin
      res[8*b +: 8] = be[b] ? upd[8*b +: 8] : cur[8*b +: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // ---------------------------------------------------------------- read path
  rd_state_e             r_rd_state;
  rd_state_e             w_rd_state_nxt;
  logic                  r_rd_req_ready;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ID_WIDTH-1:0]   r_rd_id;
  logic                  r_rd_last;
  logic                  r_rd_err;
  logic [7:0]            r_rd_cnt;
  logic [IDX_W-1:0]      r_rd_idx;

  logic                  w_rd_accept;
  logic                  w_rd_advance;
  logic                  w_rd_done;
  logic                  w_rd_acc_err;
  logic [IDX_W-1:0]      w_rd_acc_idx;
  logic [IDX_W-1:0]      w_rd_load_idx;
  logic                  w_rd_load_err;
  logic [DATA_WIDTH-1:0] w_rd_load_data;

  // Read FSM next state and beat-load selection
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_accept    = 1'b0;
    w_rd_advance   = 1'b0;
    w_rd_done      = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (r_rd_req_ready && mem_req_read_valid_i) begin
          w_rd_accept    = 1'b1;
          w_rd_state_nxt = RD_BURST;
        end else begin
          w_rd_state_nxt = RD_IDLE;
        end
      end
      RD_BURST: begin
        if (r_rd_valid && mem_resp_read_ready_i) begin
          if (r_rd_cnt == 8'd0) begin
            w_rd_done      = 1'b1;
            w_rd_state_nxt = RD_IDLE;
          end else begin
            w_rd_advance   = 1'b1;
            w_rd_state_nxt = RD_BURST;
          end
        end else begin
          w_rd_state_nxt = RD_BURST;
        end
      end
      default: begin
        w_rd_state_nxt = RD_IDLE;
      end
    endcase

    w_rd_acc_err   = (mem_req_read_cmd_i != CMD_READ) || addr_oor(mem_req_read_addr_i);
    w_rd_acc_idx   = addr_idx(mem_req_read_addr_i);
    w_rd_load_idx  = w_rd_accept ? w_rd_acc_idx : r_rd_idx;
    w_rd_load_err  = w_rd_accept ? w_rd_acc_err : r_rd_err;
    // Array read happens at the load edge; a same-edge write is not yet visible.
    w_rd_load_data = w_rd_load_err ? {DATA_WIDTH{1'b0}} : r_mem[w_rd_load_idx];
  end

  // Read FSM state and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state     <= RD_IDLE;
      r_rd_req_ready <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= {DATA_WIDTH{1'b0}};
      r_rd_id        <= {ID_WIDTH{1'b0}};
      r_rd_last      <= 1'b0;
      r_rd_err       <= 1'b0;
      r_rd_cnt       <= 8'd0;
      r_rd_idx       <= {IDX_W{1'b0}};
    end else begin
      r_rd_state     <= w_rd_state_nxt;
      r_rd_req_ready <= (w_rd_state_nxt == RD_IDLE);
      if (w_rd_accept) begin
        r_rd_valid <= 1'b1;
        r_rd_id    <= mem_req_read_id_i;
        r_rd_err   <= w_rd_acc_err;
        r_rd_cnt   <= mem_req_read_len_i;
        r_rd_last  <= (mem_req_read_len_i == 8'd0);
        r_rd_data  <= w_rd_load_data;
        r_rd_idx   <= w_rd_acc_idx + IDX_ONE;
      end else if (w_rd_advance) begin
        r_rd_cnt   <= r_rd_cnt - 8'd1;
        r_rd_last  <= (r_rd_cnt == 8'd1);
        r_rd_data  <= w_rd_load_data;
        r_rd_idx   <= r_rd_idx + IDX_ONE;
      end else if (w_rd_done) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- write path
  wr_state_e           r_wr_state;
  wr_state_e           w_wr_state_nxt;
  logic                r_wr_req_ready;
  logic                r_wr_data_ready;
  logic                r_wr_resp_valid;
  logic [ID_WIDTH-1:0] r_wr_id;
  logic                r_wr_err;
  logic [7:0]          r_wr_cnt;
  logic [IDX_W-1:0]    r_wr_idx;

  logic                w_wr_accept;
  logic                w_wr_beat;
  logic                w_wr_last_bad;
  logic                w_wr_mem_we;

  // Write FSM next state and beat qualification
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_accept    = 1'b0;
    w_wr_beat      = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (r_wr_req_ready && mem_req_write_valid_i) begin
          w_wr_accept    = 1'b1;
          w_wr_state_nxt = WR_DATA;
        end else begin
          w_wr_state_nxt = WR_IDLE;
        end
      end
      WR_DATA: begin
        if (r_wr_data_ready && mem_req_write_data_valid_i) begin
          w_wr_beat      = 1'b1;
          w_wr_state_nxt = (r_wr_cnt == 8'd0) ? WR_RESP : WR_DATA;
        end else begin
          w_wr_state_nxt = WR_DATA;
        end
      end
      WR_RESP: begin
        if (r_wr_resp_valid && mem_resp_write_ready_i) begin
          w_wr_state_nxt = WR_IDLE;
        end else begin
          w_wr_state_nxt = WR_RESP;
        end
      end
      default: begin
        w_wr_state_nxt = WR_IDLE;
      end
    endcase

    // The beat count follows len; a misplaced last flag only poisons the response.
    w_wr_last_bad = mem_req_write_data_last_i != (r_wr_cnt == 8'd0);
    w_wr_mem_we   = w_wr_beat && !r_wr_err && !rst_i;
  end

  // Write FSM state and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state      <= WR_IDLE;
      r_wr_req_ready  <= 1'b0;
      r_wr_data_ready <= 1'b0;
      r_wr_resp_valid <= 1'b0;
      r_wr_id         <= {ID_WIDTH{1'b0}};
      r_wr_err        <= 1'b0;
      r_wr_cnt        <= 8'd0;
      r_wr_idx        <= {IDX_W{1'b0}};
    end else begin
      r_wr_state      <= w_wr_state_nxt;
      r_wr_req_ready  <= (w_wr_state_nxt == WR_IDLE);
      r_wr_data_ready <= (w_wr_state_nxt == WR_DATA);
      r_wr_resp_valid <= (w_wr_state_nxt == WR_RESP);
      if (w_wr_accept) begin
        r_wr_id  <= mem_req_write_id_i;
        r_wr_err <= (mem_req_write_cmd_i != CMD_WRITE) || addr_oor(mem_req_write_addr_i);
        r_wr_cnt <= mem_req_write_len_i;
        r_wr_idx <= addr_idx(mem_req_write_addr_i);
      end else if (w_wr_beat) begin
        r_wr_err <= r_wr_err || w_wr_last_bad;
        r_wr_cnt <= r_wr_cnt - 8'd1;
        r_wr_idx <= r_wr_idx + IDX_ONE;
      end
    end
  end

  // Backing store: byte-enabled writes, never reset
  always_ff @(posedge clk_i) begin
    if (w_wr_mem_we) begin
      r_mem[r_wr_idx] <= merge_bytes(r_mem[r_wr_idx], mem_req_write_data_i,
                                     mem_req_write_data_be_i);
    end
  end

  logic w_unused;
  assign w_unused = ^{mem_req_read_addr_i[OFF_W-1:0], mem_req_write_addr_i[OFF_W-1:0]};

  assign mem_req_read_ready_o       = r_rd_req_ready;
  assign mem_resp_read_valid_o      = r_rd_valid;
  assign mem_resp_read_data_o       = r_rd_data;
  assign mem_resp_read_id_o         = r_rd_id;
  assign mem_resp_read_last_o       = r_rd_last;
  assign mem_resp_read_error_o      = r_rd_err;
  assign mem_req_write_ready_o      = r_wr_req_ready;
  assign mem_req_write_data_ready_o = r_wr_data_ready;
  assign mem_resp_write_valid_o     = r_wr_resp_valid;
  assign mem_resp_write_id_o        = r_wr_id;
  assign mem_resp_write_error_o     = r_wr_err;

endmodule

// File: tb/tb_hpdcache_mem_responder.sv
// Self-checking bench for hpdcache_mem_responder: directed vector table, hand-written
// corner sequences and randomized traffic against a word-array reference model.
module tb_hpdcache_mem_responder;
  localparam int AW = 56, IW = 7, DW = 512, MW = 64, BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [7:0]    rd_req_len;
  logic [IW-1:0] rd_req_id;
  logic [1:0]    rd_req_cmd;
  logic          rd_valid, rd_ready, rd_last, rd_err;
  logic [DW-1:0] rd_data;
  logic [IW-1:0] rd_id;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [7:0]    wr_req_len;
  logic [IW-1:0] wr_req_id;
  logic [1:0]    wr_req_cmd;
  logic          wd_valid, wd_ready, wd_last;
  logic [DW-1:0] wd_data;
  logic [BW-1:0] wd_be;
  logic          wresp_valid, wresp_ready, wresp_err;
  logic [IW-1:0] wresp_id;

  hpdcache_mem_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_req_read_valid_i(rd_req_valid), .mem_req_read_ready_o(rd_req_ready),
    .mem_req_read_addr_i(rd_req_addr), .mem_req_read_len_i(rd_req_len),
    .mem_req_read_id_i(rd_req_id), .mem_req_read_cmd_i(rd_req_cmd),
    .mem_resp_read_valid_o(rd_valid), .mem_resp_read_ready_i(rd_ready),
    .mem_resp_read_data_o(rd_data), .mem_resp_read_id_o(rd_id),
    .mem_resp_read_last_o(rd_last), .mem_resp_read_error_o(rd_err),
    .mem_req_write_valid_i(wr_req_valid), .mem_req_write_ready_o(wr_req_ready),
    .mem_req_write_addr_i(wr_req_addr), .mem_req_write_len_i(wr_req_len),
    .mem_req_write_id_i(wr_req_id), .mem_req_write_cmd_i(wr_req_cmd),
    .mem_req_write_data_valid_i(wd_valid), .mem_req_write_data_ready_o(wd_ready),
    .mem_req_write_data_i(wd_data), .mem_req_write_data_be_i(wd_be),
    .mem_req_write_data_last_i(wd_last),
    .mem_resp_write_valid_o(wresp_valid), .mem_resp_write_ready_i(wresp_ready),
    .mem_resp_write_id_o(wresp_id), .mem_resp_write_error_o(wresp_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] model_mem [MW];

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
    logic [1:0]    cmd;
    logic [DW-1:0] d0;
    bit            exp_err;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_oor(input logic [AW-1:0] addr);
    return addr[AW-1:12] != '0;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [BW-1:0] rand_be();
    logic [BW-1:0] b;
    for (int k = 0; k < BW / 32; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  // Write transaction; bad_beat >= 0 inverts the last flag on that beat.
  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [IW-1:0] id, input logic [1:0] cmd,
                          input logic [DW-1:0] d0, input logic [BW-1:0] be,
                          input int bad_beat, input bit exp_err, input string tag);
    int to;
    bit err_m;
    int base;
    int w;
    logic [DW-1:0] d;
    err_m = (cmd != 2'b01) || model_oor(addr);
    base = int'(addr[11:6]);
    wr_req_valid = 1'b1; wr_req_addr = addr; wr_req_len = len;
    wr_req_id = id; wr_req_cmd = cmd;
    to = 0;
    while (!wr_req_ready && to < 50) begin tick(); to++; end
    if (to >= 50) check({tag, " wreq timeout"}, 1'b1, 1'b0);
    tick();
    wr_req_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      d = d0 + DW'(b);
      wd_valid = 1'b1; wd_data = d; wd_be = be;
      wd_last = (b == bad_beat) ? (b != int'(len)) : (b == int'(len));
      to = 0;
      while (!wd_ready && to < 50) begin tick(); to++; end
      if (to >= 50) check({tag, " wdata timeout"}, 1'b1, 1'b0);
      tick();
      w = (base + b) % MW;
      if (!err_m)
        for (int k = 0; k < BW; k++)
          if (be[k]) model_mem[w][8*k +: 8] = d[8*k +: 8];
      if (wd_last != (b == int'(len))) err_m = 1'b1;
    end
    wd_valid = 1'b0; wd_last = 1'b0;
    to = 0;
    while (!wresp_valid && to < 50) begin tick(); to++; end
    check({tag, " wresp valid"}, wresp_valid, 1'b1);
    check({tag, " wresp id"}, wresp_id, id);
    check({tag, " wresp err"}, wresp_err, exp_err);
    wresp_ready = 1'b1;
    tick();
    wresp_ready = 1'b0;
    check({tag, " wresp drop"}, wresp_valid, 1'b0);
  endtask

  // Read transaction; expected beats come from the model, stalls are random when asked.
  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [IW-1:0] id, input logic [1:0] cmd,
                         input bit exp_err, input bit rand_ready, input string tag);
    int to;
    int base;
    logic [DW-1:0] exp_d;
    bit exp_last;
    base = int'(addr[11:6]);
    rd_req_valid = 1'b1; rd_req_addr = addr; rd_req_len = len;
    rd_req_id = id; rd_req_cmd = cmd;
    to = 0;
    while (!rd_req_ready && to < 50) begin tick(); to++; end
    if (to >= 50) check({tag, " rreq timeout"}, 1'b1, 1'b0);
    tick();
    rd_req_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      exp_d = exp_err ? '0 : model_mem[(base + b) % MW];
      exp_last = (b == int'(len));
      check($sformatf("%s b%0d valid", tag, b), rd_valid, 1'b1);
      check($sformatf("%s b%0d data", tag, b), rd_data, exp_d);
      check($sformatf("%s b%0d last", tag, b), rd_last, exp_last);
      check($sformatf("%s b%0d err", tag, b), rd_err, exp_err);
      check($sformatf("%s b%0d id", tag, b), rd_id, id);
      if (rand_ready) begin
        for (int s = 0; s < 4 && $urandom_range(0, 1) == 0; s++) begin
          rd_ready = 1'b0;
          tick();
          check($sformatf("%s b%0d stall valid", tag, b), rd_valid, 1'b1);
          check($sformatf("%s b%0d stall data", tag, b), rd_data, exp_d);
          check($sformatf("%s b%0d stall last", tag, b), rd_last, exp_last);
          check($sformatf("%s b%0d stall id", tag, b), rd_id, id);
        end
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    check({tag, " valid drop"}, rd_valid, 1'b0);
    check({tag, " rreq ready again"}, rd_req_ready, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rreq ready"}, rd_req_ready, 1'b0);
    check({tag, " rresp valid"}, rd_valid, 1'b0);
    check({tag, " wreq ready"}, wr_req_ready, 1'b0);
    check({tag, " wdata ready"}, wd_ready, 1'b0);
    check({tag, " wresp valid"}, wresp_valid, 1'b0);
    check({tag, " rdata"}, rd_data, '0);
    check({tag, " rid/last/err"}, {rd_id, rd_last, rd_err}, '0);
    check({tag, " wid/err"}, {wresp_id, wresp_err}, '0);
  endtask

  vec_t vt [10];
  logic [DW-1:0] old_w, new_w;
  logic [AW-1:0] ra;
  int to;

  initial begin
    rst_i = 1'b1;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_len = '0; rd_req_id = '0; rd_req_cmd = '0;
    rd_ready = 1'b0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_len = '0; wr_req_id = '0; wr_req_cmd = '0;
    wd_valid = 1'b0; wd_data = '0; wd_be = '0; wd_last = 1'b0; wresp_ready = 1'b0;

    vt[0] = '{1'b1, 56'h40, 8'd0, 7'h05, 2'b01, {64{8'hA5}}, 1'b0};
    vt[1] = '{1'b0, 56'h40, 8'd0, 7'h06, 2'b00, '0, 1'b0};
    vt[2] = '{1'b1, 56'hF80, 8'd3, 7'h11, 2'b01, 512'd1, 1'b0};
    vt[3] = '{1'b0, 56'hF80, 8'd3, 7'h12, 2'b00, '0, 1'b0};
    vt[4] = '{1'b0, 56'h100_0000_0040, 8'd1, 7'h21, 2'b00, '0, 1'b1};
    vt[5] = '{1'b0, 56'h40, 8'd1, 7'h22, 2'b10, '0, 1'b1};
    vt[6] = '{1'b1, 56'h100_0000_0040, 8'd0, 7'h23, 2'b01, '1, 1'b1};
    vt[7] = '{1'b1, 56'h40, 8'd0, 7'h24, 2'b00, '1, 1'b1};
    vt[8] = '{1'b0, 56'h40, 8'd0, 7'h25, 2'b00, '0, 1'b0};
    vt[9] = '{1'b0, 56'h4F, 8'd1, 7'h7F, 2'b00, '0, 1'b0};

    repeat (3) tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();
    check("post-reset rreq ready", rd_req_ready, 1'b1);
    check("post-reset wreq ready", wr_req_ready, 1'b1);
    check("post-reset wdata ready", wd_ready, 1'b0);

    do_write('0, 8'd63, 7'h01, 2'b01, {16{32'h1234_5678}}, '1, -1, 1'b0, "preload");

    foreach (vt[i]) begin
      if (vt[i].wr)
        do_write(vt[i].addr, vt[i].len, vt[i].id, vt[i].cmd, vt[i].d0, '1, -1,
                 vt[i].exp_err, $sformatf("vec%0d", i));
      else
        do_read(vt[i].addr, vt[i].len, vt[i].id, vt[i].cmd, vt[i].exp_err, 1'b0,
                $sformatf("vec%0d", i));
    end
    check("wrap word 0", model_mem[0], 512'd3);

    do_write(56'h200, 8'd1, 7'h30, 2'b01, rand_word(), '1, 0, 1'b1, "lastbad");
    do_write(56'h200, 8'd1, 7'h31, 2'b01, rand_word(), '1, -1, 1'b0, "resync");
    do_read(56'h200, 8'd1, 7'h32, 2'b00, 1'b0, 1'b0, "resync rd");

    do_read(56'h300, 8'd7, 7'h33, 2'b00, 1'b0, 1'b1, "stall8");

    old_w = model_mem[10];
    new_w = ~old_w;
    wr_req_valid = 1'b1; wr_req_addr = 56'd640; wr_req_len = 8'd0;
    wr_req_id = 7'h40; wr_req_cmd = 2'b01;
    to = 0;
    while (!wr_req_ready && to < 50) begin tick(); to++; end
    tick();
    wr_req_valid = 1'b0;
    wd_valid = 1'b1; wd_data = new_w; wd_be = '1; wd_last = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = 56'd640; rd_req_len = 8'd0;
    rd_req_id = 7'h41; rd_req_cmd = 2'b00;
    check("coll wdata ready", wd_ready, 1'b1);
    check("coll rreq ready", rd_req_ready, 1'b1);
    tick();
    wd_valid = 1'b0; wd_last = 1'b0; rd_req_valid = 1'b0;
    check("coll read old", rd_data, old_w);
    model_mem[10] = new_w;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    to = 0;
    while (!wresp_valid && to < 50) begin tick(); to++; end
    check("coll wresp valid", wresp_valid, 1'b1);
    check("coll wresp err", wresp_err, 1'b0);
    wresp_ready = 1'b1;
    tick();
    wresp_ready = 1'b0;
    do_read(56'd640, 8'd0, 7'h42, 2'b00, 1'b0, 1'b0, "coll after");

    wr_req_valid = 1'b1; wr_req_addr = 56'd320; wr_req_len = 8'd3;
    wr_req_id = 7'h50; wr_req_cmd = 2'b01;
    to = 0;
    while (!wr_req_ready && to < 50) begin tick(); to++; end
    tick();
    wr_req_valid = 1'b0;
    check("rst wdata ready before", wd_ready, 1'b1);
    rst_i = 1'b1;
    tick();
    check_all_zero("midrst");
    tick();
    rst_i = 1'b0;
    tick();
    check("midrst rreq ready", rd_req_ready, 1'b1);
    check("midrst wreq ready", wr_req_ready, 1'b1);
    wd_valid = 1'b1; wd_data = '0; wd_be = '1; wd_last = 1'b1;
    repeat (2) begin
      tick();
      check("idle wdata stall", wd_ready, 1'b0);
    end
    wd_valid = 1'b0; wd_last = 1'b0;
    do_read(56'd320, 8'd0, 7'h51, 2'b00, 1'b0, 1'b0, "midrst old");

    for (int i = 0; i < 40; i++) begin
      bit wr;
      logic [1:0] cmd;
      logic [7:0] len;
      wr = $urandom_range(0, 1);
      ra = {44'd0, 6'($urandom), 6'($urandom)};
      if ($urandom_range(0, 7) == 0) ra[$urandom_range(12, AW - 1)] = 1'b1;
      cmd = wr ? 2'b01 : 2'b00;
      if ($urandom_range(0, 5) == 0) cmd = 2'($urandom);
      len = 8'($urandom_range(0, 7));
      if (wr)
        do_write(ra, len, 7'($urandom), cmd, rand_word(), rand_be(), -1,
                 (cmd != 2'b01) || model_oor(ra), $sformatf("rnd%0d", i));
      else
        do_read(ra, len, 7'($urandom), cmd, (cmd != 2'b00) || model_oor(ra), 1'b1,
                $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hpdcache_mem_responder.md
Name: hpdcache_mem_responder

Overview:
Synthesizable memory-side responder for the HPDcache memory interface. It terminates the cache's read-request, read-response, write-request, write-data and write-response channels against an internal register-array memory. It is used as the far end of the cache in synthesis-level and FPGA test harnesses. Read and write paths are independent. Each path handles one outstanding transaction at a time.

Parameters:
ADDR_WIDTH, 56, byte address width of request channels
ID_WIDTH, 7, transaction ID width
DATA_WIDTH, 512, beat width in bits (power of 2, >=64)
MEM_WORDS, 64, number of DATA_WIDTH-bit words in backing array (power of 2, >=2)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
mem_req_read_valid_i  in  1  read request valid
mem_req_read_ready_o  out  1  read request ready
mem_req_read_addr_i  in  ADDR_WIDTH  byte address of first beat
mem_req_read_len_i  in  8  beats minus one
mem_req_read_id_i  in  ID_WIDTH  transaction ID
mem_req_read_cmd_i  in  2  00 READ, 01 WRITE, 10 ATOMIC, 11 reserved
mem_resp_read_valid_o  out  1  read beat valid
mem_resp_read_ready_i  in  1  read beat ready
mem_resp_read_data_o  out  DATA_WIDTH  beat data
mem_resp_read_id_o  out  ID_WIDTH  echoed ID
mem_resp_read_last_o  out  1  final beat
mem_resp_read_error_o  out  1  error flag
mem_req_write_valid_i / mem_req_write_ready_o  in/out  1  write request handshake
mem_req_write_addr_i, _len_i, _id_i, _cmd_i  in  ADDR_WIDTH/8/ID_WIDTH/2  same encoding as read request
mem_req_write_data_valid_i / mem_req_write_data_ready_o  in/out  1  write data handshake
mem_req_write_data_i  in  DATA_WIDTH  beat data
mem_req_write_data_be_i  in  DATA_WIDTH/8  byte enables
mem_req_write_data_last_i  in  1  final data beat
mem_resp_write_valid_o / mem_resp_write_ready_i  out/in  1  write response handshake
mem_resp_write_id_o  out  ID_WIDTH  echoed ID
mem_resp_write_error_o  out  1  error flag

Behaviour:
- Reset: all valid and ready outputs are 0. Data, ID, last and error outputs are 0. Both FSMs go to IDLE. The memory array is not reset.
- A handshake occurs when valid and ready are both 1 on a rising edge. Outputs stay stable while valid=1 and ready=0.
- Word index = addr[log2(DATA_WIDTH/8) +: log2(MEM_WORDS)]. The address is out of range if any higher address bit is 1. Offset bits below the beat are ignored.
- Within a burst the index increments by 1 per beat, modulo MEM_WORDS. The range check applies only to the start address.
- Read FSM, IDLE -> RBURST -> IDLE:
  - IDLE: read request ready=1.
  - Accept at edge T: latch ID, beat counter = len, error = (cmd!=READ) or out of range. First beat is valid at T+1.
  - Data = mem[idx], read at the beat-load edge. Data is 0 when error=1.
  - Each resp handshake with counter>0: decrement counter, load the next beat. Back-to-back beats are allowed.
  - last = (counter==0). Handshake on the last beat -> IDLE, read request ready=1 the next cycle.
  - Error bursts still return len+1 beats.
- Write FSM, IDLE -> WDATA -> WRESP -> IDLE:
  - IDLE: write request ready=1, write data ready=0.
  - Accept: latch ID, index and counter. err = (cmd!=WRITE) or out of range.
  - WDATA: write data ready=1. Each beat with err=0 writes mem[idx] byte-wise per be.
  - After the beat with counter==0 -> WRESP. If data last_i does not equal (counter==0) on any beat, err becomes sticky 1. The beat count is still governed by len.
  - WRESP: resp valid=1, ID and error driven. Handshake -> IDLE.
- Collision: a write beat and a read-beat load to the same index on the same edge; the read returns the old word.
- Write data presented while the write FSM is in IDLE or WRESP stalls (ready=0). It is never dropped.
- Reset mid-burst aborts both FSMs immediately. Memory contents written before reset are retained.

Test Plan:
- Write addr 0x40, len 0, be all-1, data 0xA5.., then read addr 0x40 len 0 -> write response error=0; read returns one beat, data 0xA5.., last=1, error=0, ID echoed, valid at T+1.
- Write len 3 from word 62 with data 1,2,3,4 -> words 62, 63, 0, 1 hold 1, 2, 3, 4 (wrap). A read len 3 from word 62 returns 1,2,3,4 back-to-back with mem_resp_read_ready_i tied 1; last=1 on beat 4 only.
- Read with addr bit 40 set, or cmd=ATOMIC, len 1 -> two beats, data 0, error=1 on both, memory unchanged.
- Write len 1 with data last_i=1 on beat 0 -> two beats consumed, response error=1.
- mem_resp_read_ready_i toggled 0/1 randomly during a len-7 burst -> data, ID and last stay stable while stalled, and 8 beats are delivered in order.
- rst_i asserted mid-WDATA, then read of a previously written word -> all valid/ready outputs are 0 during reset, the FSMs restart in IDLE, and the old word is intact.
